// File: rtl/ex_hazard_ctrl.sv
// rtl/ex_hazard_ctrl.sv - RAW hazard detection and forwarding-select register for the dual-slot VLIW pipeline
//
// Tracks the writers of the bundles now in EX (stage A) and MEM (stage Z). For each
// source the ID bundle uses, it picks a forwarding select, or raises stall/bubble when
// forwarding cannot supply the value in time.
//
// Optional feature macro: VLIW_FORWARDING_EN. When it is undefined, every select is 0
// and any match against an A or Z writer stalls until that writer has retired.
//
// Ports:
//   clk, reset (async, active-low)
//   id_valid, id_alu_regWrite, id_mem_regWrite, id_memRead, id_memWrite, id_aluSrcB
//   id_alu_rn, id_alu_rm, id_alu_rd, id_mem_rn, id_mem_rd : ID bundle register fields
//   flush                    : redirect, kills the ID bundle
//   stall, bubble            : hold IF/ID, load a NOP into ID/EX
//   f_alu_reg_rn_sel, f_alu_reg_rm_sel, f_mem_reg_rn_sel : 0 rf, 1 EX/MEM ALU, 2 MEM/WB ALU, 3 MEM/WB load
//   f_mem_reg_rd_sel         : store data, 0 rf, 1 EX/MEM ALU
//   stall_count              : saturating count of stall cycles
module ex_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic        id_alu_regWrite,
  input  logic        id_mem_regWrite,
  input  logic        id_memRead,
  input  logic        id_memWrite,
  input  logic        id_aluSrcB,
  input  logic [2:0]  id_alu_rn,
  input  logic [2:0]  id_alu_rm,
  input  logic [2:0]  id_alu_rd,
  input  logic [2:0]  id_mem_rn,
  input  logic [2:0]  id_mem_rd,
  input  logic        flush,
  output logic        stall,
  output logic        bubble,
  output logic [1:0]  f_alu_reg_rn_sel,
  output logic [1:0]  f_alu_reg_rm_sel,
  output logic [1:0]  f_mem_reg_rn_sel,
  output logic        f_mem_reg_rd_sel,
  output logic [15:0] stall_count
);

  // Writer history: A = bundle in EX, Z = bundle in MEM.
  logic       r_a_alu_v, r_a_ld_v, r_z_alu_v, r_z_ld_v;
  logic [2:0] r_a_alu_rd, r_a_ld_rd, r_z_alu_rd, r_z_ld_rd;

  logic [1:0]  r_alu_rn_sel, r_alu_rm_sel, r_mem_rn_sel;
  logic        r_mem_rd_sel;
  logic [15:0] r_stall_count;

  // Match vector for one source: {A load, A ALU, Z load, Z ALU}.
  function automatic logic [3:0] match_vec(
    input logic [2:0] s,
    input logic a_ld_v, input logic [2:0] a_ld_rd,
    input logic a_alu_v, input logic [2:0] a_alu_rd,
    input logic z_ld_v, input logic [2:0] z_ld_rd,
    input logic z_alu_v, input logic [2:0] z_alu_rd);
    match_vec = {a_ld_v && (a_ld_rd == s), a_alu_v && (a_alu_rd == s),
                 z_ld_v && (z_ld_rd == s), z_alu_v && (z_alu_rd == s)};
  endfunction

  // Operand source: returns {hazard, sel[1:0]}.
  function automatic logic [2:0] op_chk(input logic used, input logic [3:0] m);
`ifdef VLIW_FORWARDING_EN
    // Nearest writer wins; within a stage the load outranks the ALU slot.
    if (!used)     op_chk = 3'b000;
    else if (m[3]) op_chk = 3'b100;
    else if (m[2]) op_chk = 3'b001;
    else if (m[1]) op_chk = 3'b011;
    else if (m[0]) op_chk = 3'b010;
    else           op_chk = 3'b000;
`else
    op_chk = {used & (|m), 2'b00};
`endif
  endfunction

  // Store data only has an EX/MEM ALU bypass; anything else in Z must retire first.
  function automatic logic [1:0] st_chk(input logic used, input logic [3:0] m);
`ifdef VLIW_FORWARDING_EN
    if (!used)            st_chk = 2'b00;
    else if (m[3])        st_chk = 2'b10;
    else if (m[2])        st_chk = 2'b01;
    else if (m[1] | m[0]) st_chk = 2'b10;
    else                  st_chk = 2'b00;
`else
    st_chk = {used & (|m), 1'b0};
`endif
  endfunction

  logic       w_use_alu_rn, w_use_alu_rm, w_use_mem_rn, w_use_mem_rd;
  logic [3:0] w_m_alu_rn, w_m_alu_rm, w_m_mem_rn, w_m_mem_rd;
  logic [2:0] w_c_alu_rn, w_c_alu_rm, w_c_mem_rn;
  logic [1:0] w_c_mem_rd;
  logic       w_hazard, w_stall;

  assign w_use_alu_rn = id_alu_regWrite;
  assign w_use_alu_rm = id_alu_regWrite & ~id_aluSrcB;
  assign w_use_mem_rn = id_memRead | id_memWrite;
  assign w_use_mem_rd = id_memWrite;

  assign w_m_alu_rn = match_vec(id_alu_rn, r_a_ld_v, r_a_ld_rd, r_a_alu_v, r_a_alu_rd,
                                r_z_ld_v, r_z_ld_rd, r_z_alu_v, r_z_alu_rd);
  assign w_m_alu_rm = match_vec(id_alu_rm, r_a_ld_v, r_a_ld_rd, r_a_alu_v, r_a_alu_rd,
                                r_z_ld_v, r_z_ld_rd, r_z_alu_v, r_z_alu_rd);
  assign w_m_mem_rn = match_vec(id_mem_rn, r_a_ld_v, r_a_ld_rd, r_a_alu_v, r_a_alu_rd,
                                r_z_ld_v, r_z_ld_rd, r_z_alu_v, r_z_alu_rd);
  assign w_m_mem_rd = match_vec(id_mem_rd, r_a_ld_v, r_a_ld_rd, r_a_alu_v, r_a_alu_rd,
                                r_z_ld_v, r_z_ld_rd, r_z_alu_v, r_z_alu_rd);

  assign w_c_alu_rn = op_chk(w_use_alu_rn, w_m_alu_rn);
  assign w_c_alu_rm = op_chk(w_use_alu_rm, w_m_alu_rm);
  assign w_c_mem_rn = op_chk(w_use_mem_rn, w_m_mem_rn);
  assign w_c_mem_rd = st_chk(w_use_mem_rd, w_m_mem_rd);

  assign w_hazard = w_c_alu_rn[2] | w_c_alu_rm[2] | w_c_mem_rn[2] | w_c_mem_rd[1];
  // flush kills the ID bundle, so its hazards are moot.
  assign w_stall  = id_valid & w_hazard & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a_alu_v     <= 1'b0;
      r_a_alu_rd    <= 3'd0;
      r_a_ld_v      <= 1'b0;
      r_a_ld_rd     <= 3'd0;
      r_z_alu_v     <= 1'b0;
      r_z_alu_rd    <= 3'd0;
      r_z_ld_v      <= 1'b0;
      r_z_ld_rd     <= 3'd0;
      r_alu_rn_sel  <= 2'd0;
      r_alu_rm_sel  <= 2'd0;
      r_mem_rn_sel  <= 2'd0;
      r_mem_rd_sel  <= 1'b0;
      r_stall_count <= 16'd0;
    end else begin
      r_z_alu_v  <= r_a_alu_v;
      r_z_alu_rd <= r_a_alu_rd;
      r_z_ld_v   <= r_a_ld_v;
      r_z_ld_rd  <= r_a_ld_rd;
      if (flush | w_stall) begin
        // A bubble (or killed bundle) enters EX: no writers, no forwarding.
        r_a_alu_v    <= 1'b0;
        r_a_alu_rd   <= 3'd0;
        r_a_ld_v     <= 1'b0;
        r_a_ld_rd    <= 3'd0;
        r_alu_rn_sel <= 2'd0;
        r_alu_rm_sel <= 2'd0;
        r_mem_rn_sel <= 2'd0;
        r_mem_rd_sel <= 1'b0;
      end else begin
        r_a_alu_v    <= id_valid & id_alu_regWrite;
        r_a_alu_rd   <= id_alu_rd;
        r_a_ld_v     <= id_valid & id_memRead & id_mem_regWrite;
        r_a_ld_rd    <= id_mem_rd;
        r_alu_rn_sel <= w_c_alu_rn[1:0];
        r_alu_rm_sel <= w_c_alu_rm[1:0];
        r_mem_rn_sel <= w_c_mem_rn[1:0];
        r_mem_rd_sel <= w_c_mem_rd[0];
      end
      if (w_stall && (r_stall_count != 16'hFFFF))
        r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall            = w_stall;
  assign bubble           = w_stall;
  assign f_alu_reg_rn_sel = r_alu_rn_sel;
  assign f_alu_reg_rm_sel = r_alu_rm_sel;
  assign f_mem_reg_rn_sel = r_mem_rn_sel;
  assign f_mem_reg_rd_sel = r_mem_rd_sel;
  assign stall_count      = r_stall_count;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb/tb_ex_hazard_ctrl.sv - self-checking bench for ex_hazard_ctrl
`timescale 1ns/1ps
module tb_ex_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        id_valid = 1'b0, id_alu_regWrite = 1'b0, id_mem_regWrite = 1'b0;
  logic        id_memRead = 1'b0, id_memWrite = 1'b0, id_aluSrcB = 1'b0;
  logic [2:0]  id_alu_rn = 3'd0, id_alu_rm = 3'd0, id_alu_rd = 3'd0;
  logic [2:0]  id_mem_rn = 3'd0, id_mem_rd = 3'd0;
  logic        flush = 1'b0;
  logic        stall, bubble;
  logic [1:0]  f_alu_reg_rn_sel, f_alu_reg_rm_sel, f_mem_reg_rn_sel;
  logic        f_mem_reg_rd_sel;
  logic [15:0] stall_count;

  int n_total = 0;
  int n_pass  = 0;

  ex_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_alu_regWrite(id_alu_regWrite), .id_mem_regWrite(id_mem_regWrite),
    .id_memRead(id_memRead), .id_memWrite(id_memWrite), .id_aluSrcB(id_aluSrcB),
    .id_alu_rn(id_alu_rn), .id_alu_rm(id_alu_rm), .id_alu_rd(id_alu_rd),
    .id_mem_rn(id_mem_rn), .id_mem_rd(id_mem_rd), .flush(flush),
    .stall(stall), .bubble(bubble),
    .f_alu_reg_rn_sel(f_alu_reg_rn_sel), .f_alu_reg_rm_sel(f_alu_reg_rm_sel),
    .f_mem_reg_rn_sel(f_mem_reg_rn_sel), .f_mem_reg_rd_sel(f_mem_reg_rd_sel),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Reference model: the writers of the last two bundles issued into EX.
  typedef struct {
    logic       alu_w;
    logic [2:0] alu_rd;
    logic       ld_w;
    logic [2:0] ld_rd;
  } wr_t;
  wr_t hist[2];  // [0] now in EX, [1] now in MEM
  int  exp_count;

  function automatic void ref_src(input logic used, input logic [2:0] s,
                                  output logic hz, output logic [1:0] sel);
    hz = 1'b0;
    sel = 2'd0;
    if (!used) return;
    for (int age = 0; age < 2; age++) begin
`ifdef VLIW_FORWARDING_EN
      if (hist[age].ld_w && hist[age].ld_rd == s) begin
        if (age == 0) hz = 1'b1; else sel = 2'd3;
        return;
      end
      if (hist[age].alu_w && hist[age].alu_rd == s) begin
        sel = (age == 0) ? 2'd1 : 2'd2;
        return;
      end
`else
      if ((hist[age].ld_w && hist[age].ld_rd == s) || (hist[age].alu_w && hist[age].alu_rd == s))
        hz = 1'b1;
`endif
    end
  endfunction

  function automatic void ref_store(input logic used, input logic [2:0] s,
                                    output logic hz, output logic sel);
    logic ld0, alu0, any1;
    hz = 1'b0;
    sel = 1'b0;
    if (!used) return;
    ld0  = hist[0].ld_w && hist[0].ld_rd == s;
    alu0 = hist[0].alu_w && hist[0].alu_rd == s;
    any1 = (hist[1].ld_w && hist[1].ld_rd == s) || (hist[1].alu_w && hist[1].alu_rd == s);
`ifdef VLIW_FORWARDING_EN
    if (ld0)       hz = 1'b1;
    else if (alu0) sel = 1'b1;
    else if (any1) hz = 1'b1;
`else
    hz = ld0 | alu0 | any1;
`endif
  endfunction

  task automatic drive(input logic v, aw, mwr, mr, mw, sb,
                       input logic [2:0] arn, arm, ard, mrn, mrd, input logic fl);
    id_valid = v; id_alu_regWrite = aw; id_mem_regWrite = mwr;
    id_memRead = mr; id_memWrite = mw; id_aluSrcB = sb;
    id_alu_rn = arn; id_alu_rm = arm; id_alu_rd = ard;
    id_mem_rn = mrn; id_mem_rd = mrd; flush = fl;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 0);
  endtask

  // Called away from a clock edge; leaves history and count cleared.
  task automatic do_reset();
    idle_in();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_total++;
    if ({stall, bubble, f_alu_reg_rn_sel, f_alu_reg_rm_sel, f_mem_reg_rn_sel, f_mem_reg_rd_sel} !== 9'd0) begin
      $display("FAIL reset_outputs: got %b expected 0", {stall, bubble, f_alu_reg_rn_sel,
               f_alu_reg_rm_sel, f_mem_reg_rn_sel, f_mem_reg_rd_sel});
    end else n_pass++;
    n_total++;
    if (stall_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", stall_count);
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // ALU writes r6; the next bundle reads r6 on alu_rn.
  task automatic test_alu_forward();
    do_reset();
    drive(1, 1, 0, 0, 0, 1, 3'd0, 3'd0, 3'd6, 3'd0, 3'd0, 0);
    tick();
    drive(1, 1, 0, 0, 0, 1, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 0);
    #1;
`ifdef VLIW_FORWARDING_EN
    n_total++;
    if (stall !== 1'b0) $display("FAIL alu_fwd_stall: got %b expected 0", stall); else n_pass++;
    tick();
    n_total++;
    if (f_alu_reg_rn_sel !== 2'd1) $display("FAIL alu_fwd_sel: got %0d expected 1", f_alu_reg_rn_sel);
    else n_pass++;
`else
    for (int c = 0; c < 3; c++) begin
      n_total++;
      if (stall !== (c < 2)) $display("FAIL alu_nofwd_stall c%0d: got %b expected %b", c, stall, c < 2);
      else n_pass++;
      tick();
      n_total++;
      if (f_alu_reg_rn_sel !== 2'd0) $display("FAIL alu_nofwd_sel c%0d: got %0d expected 0", c, f_alu_reg_rn_sel);
      else n_pass++;
    end
    n_total++;
    if (stall_count !== 16'd2) $display("FAIL alu_nofwd_count: got %0d expected 2", stall_count);
    else n_pass++;
`endif
  endtask

  // Load r2, then an ALU bundle reading r2 on rm.
  task automatic test_load_use();
    int ncyc;
`ifdef VLIW_FORWARDING_EN
    ncyc = 1;
`else
    ncyc = 2;
`endif
    do_reset();
    drive(1, 0, 1, 1, 0, 0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 0);
    tick();
    drive(1, 1, 0, 0, 0, 0, 3'd7, 3'd2, 3'd7, 3'd0, 3'd0, 0);
    for (int c = 0; c <= ncyc; c++) begin
      #1;
      n_total++;
      if (stall !== (c < ncyc) || bubble !== (c < ncyc))
        $display("FAIL load_use_stall c%0d: got stall=%b bubble=%b expected %b", c, stall, bubble, c < ncyc);
      else n_pass++;
      @(posedge clk);
    end
    #1;
    n_total++;
`ifdef VLIW_FORWARDING_EN
    if (f_alu_reg_rm_sel !== 2'd3) $display("FAIL load_use_sel: got %0d expected 3", f_alu_reg_rm_sel);
`else
    if (f_alu_reg_rm_sel !== 2'd0) $display("FAIL load_use_sel: got %0d expected 0", f_alu_reg_rm_sel);
`endif
    else n_pass++;
    n_total++;
    if (stall_count !== 16'(ncyc)) $display("FAIL load_use_count: got %0d expected %0d", stall_count, ncyc);
    else n_pass++;
  endtask

  // Load r3, then a store of r3: two stall cycles in either build.
  task automatic test_store_after_load();
    do_reset();
    drive(1, 0, 1, 1, 0, 0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 0);
    tick();
    drive(1, 0, 0, 0, 1, 0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd3, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_total++;
      if (stall !== (c < 2)) $display("FAIL store_ld_stall c%0d: got %b expected %b", c, stall, c < 2);
      else n_pass++;
      @(posedge clk);
    end
    #1;
    n_total++;
    if (f_mem_reg_rd_sel !== 1'b0) $display("FAIL store_ld_sel: got %b expected 0", f_mem_reg_rd_sel);
    else n_pass++;
    n_total++;
    if (stall_count !== 16'd2) $display("FAIL store_ld_count: got %0d expected 2", stall_count);
    else n_pass++;
  endtask

  // Load r4 in A while the consumer is flushed; the load then sits in Z.
  task automatic test_flush();
    do_reset();
    drive(1, 0, 1, 1, 0, 0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 0);
    tick();
    drive(1, 1, 0, 0, 0, 1, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 1);
    #1;
    n_total++;
    if (stall !== 1'b0 || bubble !== 1'b0) $display("FAIL flush_stall: got %b%b expected 00", stall, bubble);
    else n_pass++;
    tick();
    n_total++;
    if ({f_alu_reg_rn_sel, f_alu_reg_rm_sel, f_mem_reg_rn_sel, f_mem_reg_rd_sel} !== 7'd0)
      $display("FAIL flush_sel: got %b expected 0", {f_alu_reg_rn_sel, f_alu_reg_rm_sel,
               f_mem_reg_rn_sel, f_mem_reg_rd_sel});
    else n_pass++;
    drive(1, 1, 0, 0, 0, 1, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 0);
    #1;
    n_total++;
`ifdef VLIW_FORWARDING_EN
    if (stall !== 1'b0) $display("FAIL flush_next_stall: got %b expected 0", stall); else n_pass++;
    tick();
    n_total++;
    if (f_alu_reg_rn_sel !== 2'd3) $display("FAIL flush_next_sel: got %0d expected 3", f_alu_reg_rn_sel);
    else n_pass++;
`else
    if (stall !== 1'b1) $display("FAIL flush_next_stall: got %b expected 1", stall); else n_pass++;
`endif
  endtask

  // Both slots write r5; consumer two bundles later sees the load value.
  task automatic test_dual_writer();
    do_reset();
    drive(1, 1, 1, 1, 0, 1, 3'd7, 3'd0, 3'd5, 3'd7, 3'd5, 0);
    tick();
    idle_in();
    tick();
    drive(1, 1, 0, 0, 0, 1, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 0);
    #1;
    n_total++;
`ifdef VLIW_FORWARDING_EN
    if (stall !== 1'b0) $display("FAIL dual_stall: got %b expected 0", stall); else n_pass++;
    tick();
    n_total++;
    if (f_alu_reg_rn_sel !== 2'd3) $display("FAIL dual_sel: got %0d expected 3", f_alu_reg_rn_sel);
    else n_pass++;
`else
    if (stall !== 1'b1) $display("FAIL dual_stall: got %b expected 1", stall); else n_pass++;
`endif
  endtask

  // Asynchronous reset while a load-use stall is asserted.
  task automatic test_reset_mid_stall();
    do_reset();
    drive(1, 0, 1, 1, 0, 0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 0);
    tick();
    drive(1, 1, 0, 0, 0, 0, 3'd7, 3'd2, 3'd7, 3'd0, 3'd0, 0);
    #1;
    n_total++;
    if (stall !== 1'b1) $display("FAIL mid_pre_stall: got %b expected 1", stall); else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if (stall !== 1'b0 || bubble !== 1'b0) $display("FAIL mid_reset_stall: got %b%b expected 00", stall, bubble);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if (stall !== 1'b0) $display("FAIL mid_after_stall: got %b expected 0", stall); else n_pass++;
    n_total++;
    if (stall_count !== 16'd0) $display("FAIL mid_after_count: got %0d expected 0", stall_count);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic       h0, h1, h2, h3, e_stall, e_mrd;
    logic [1:0] e_rn, e_rm, e_mrn;
    wr_t        nw;
    do_reset();
    for (int a = 0; a < 2; a++) hist[a] = '{1'b0, 3'd0, 1'b0, 3'd0};
    exp_count = 0;
    for (int c = 0; c < 600; c++) begin
      drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 1'($urandom_range(0, 9) == 0));
      ref_src(id_alu_regWrite, id_alu_rn, h0, e_rn);
      ref_src(id_alu_regWrite & !id_aluSrcB, id_alu_rm, h1, e_rm);
      ref_src(id_memRead | id_memWrite, id_mem_rn, h2, e_mrn);
      ref_store(id_memWrite, id_mem_rd, h3, e_mrd);
      e_stall = id_valid & (h0 | h1 | h2 | h3) & !flush;
      #1;
      n_total++;
      if (stall !== e_stall || bubble !== e_stall)
        $display("FAIL rand_stall c%0d: got %b/%b expected %b", c, stall, bubble, e_stall);
      else n_pass++;
      nw = '{id_valid & id_alu_regWrite, id_alu_rd, id_valid & id_memRead & id_mem_regWrite, id_mem_rd};
      if (e_stall | flush) begin
        nw = '{1'b0, 3'd0, 1'b0, 3'd0};
        e_rn = 2'd0; e_rm = 2'd0; e_mrn = 2'd0; e_mrd = 1'b0;
      end
      if (e_stall && exp_count < 65535) exp_count++;
      tick();
      hist[1] = hist[0];
      hist[0] = nw;
      n_total++;
      if ({f_alu_reg_rn_sel, f_alu_reg_rm_sel, f_mem_reg_rn_sel, f_mem_reg_rd_sel} !== {e_rn, e_rm, e_mrn, e_mrd})
        $display("FAIL rand_sel c%0d: got %b expected %b", c,
                 {f_alu_reg_rn_sel, f_alu_reg_rm_sel, f_mem_reg_rn_sel, f_mem_reg_rd_sel},
                 {e_rn, e_rm, e_mrn, e_mrd});
      else n_pass++;
      n_total++;
      if (stall_count !== 16'(exp_count))
        $display("FAIL rand_count c%0d: got %0d expected %0d", c, stall_count, exp_count);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_alu_forward();
    test_load_use();
    test_store_after_load();
    test_flush();
    test_dual_writer();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
